// File: rtl/motion_segment_sequencer_pkg.sv
// motion_pkg: shared types and constants for the motion channel sequencers.
//   seq_state_t         sequencer state encoding
//   SEG_SET_V/A/J       bit positions inside the seg_set field
//   DEF_LEN_W/DEF_DIV_W default segment-length and divider widths
package motion_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_ABORT = 2'd3
  } seq_state_t;

  localparam int unsigned SEG_SET_V = 0;
  localparam int unsigned SEG_SET_A = 1;
  localparam int unsigned SEG_SET_J = 2;

  localparam int unsigned DEF_LEN_W = 32;
  localparam int unsigned DEF_DIV_W = 16;

endpackage

// File: rtl/motion_segment_sequencer_if.sv
// Segment queue handshake between a segment source and a sequencer.
//   seg_valid/seg_ready  valid/ready handshake
//   seg_v/seg_a/seg_j    signed load values
//   seg_set              {set_j,set_a,set_v} enables
//   seg_last             final segment of the move
//   seg_len              acc_step ticks for this segment
// modports: master = queue source, slave = sequencer.
interface motion_segment_sequencer_if #(
  parameter int unsigned LEN_W = motion_pkg::DEF_LEN_W
) ();

  logic             seg_valid;
  logic             seg_ready;
  logic [31:0]      seg_v;
  logic [31:0]      seg_a;
  logic [31:0]      seg_j;
  logic [2:0]       seg_set;
  logic             seg_last;
  logic [LEN_W-1:0] seg_len;

  modport master (
    output seg_valid, seg_v, seg_a, seg_j, seg_set, seg_last, seg_len,
    input  seg_ready
  );

  modport slave (
    input  seg_valid, seg_v, seg_a, seg_j, seg_set, seg_last, seg_len,
    output seg_ready
  );

endinterface

// File: rtl/motion_segment_sequencer_tick_div.sv
// motion_tick_div: acc_step period divider.
//   clear   reload the counter (period sampled from div), suppress tick
//   enable  count this cycle
//   div     period in clk cycles, 0 treated as 1; sampled at each reload
//   wrap    combinational: the counter expires this cycle (tick next cycle)
//   tick    registered one-cycle pulse every max(div,1) enabled cycles
module motion_tick_div #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  output logic             wrap,
  output logic             tick
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] reload;

  always_comb begin
    reload = (div == '0) ? '0 : div - DIV_W'(1);
    wrap   = enable && (cnt == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (clear) begin
      cnt  <= reload;
      tick <= 1'b0;
    end else if (enable) begin
      if (cnt == '0) begin
        cnt  <= reload;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt - DIV_W'(1);
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/motion_segment_sequencer.sv
// motion_segment_sequencer: runs one acc_profile_gen channel through a queue
// of motion segments.
//   clk, reset          clock, asynchronous active-high reset
//   start, abort_req    begin execution / request controlled stop
//   step_div            acc_step period (0 treated as 1)
//   seg                 segment queue (slave side)
//   gen_stopped         generator stopped status
//   acc_step, load, set_v/a/j, v_val/a_val/j_val, abort   generator controls
//   busy, done, underrun                                  status
// Optional: MOTION_SEQ_STEPCOUNT_EN adds step_count, the saturating number
// of acc_step pulses since the last start.
module motion_segment_sequencer
  import motion_pkg::*;
#(
  parameter int unsigned LEN_W = DEF_LEN_W,
  parameter int unsigned DIV_W = DEF_DIV_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort_req,
  input  logic [DIV_W-1:0]            step_div,
  motion_segment_sequencer_if.slave   seg,
  input  logic                        gen_stopped,
  output logic                        acc_step,
  output logic                        load,
  output logic                        set_v,
  output logic                        set_a,
  output logic                        set_j,
  output logic [31:0]                 v_val,
  output logic [31:0]                 a_val,
  output logic [31:0]                 j_val,
  output logic                        abort,
  output logic                        busy,
  output logic                        done,
`ifdef MOTION_SEQ_STEPCOUNT_EN
  output logic                        underrun,
  output logic [31:0]                 step_count
`else
  output logic                        underrun
`endif
);

  seq_state_t       state;
  seq_state_t       state_n;
  logic [LEN_W-1:0] remaining;
  logic             last;

  logic div_en;
  logic div_clr;
  logic div_wrap;
  logic done_n;
  logic underrun_set;
  logic start_clr;

  motion_tick_div #(
    .DIV_W (DIV_W)
  ) u_tick_div (
    .clk    (clk),
    .reset  (reset),
    .clear  (div_clr),
    .enable (div_en),
    .div    (step_div),
    .wrap   (div_wrap),
    .tick   (acc_step)
  );

  // A zero-length segment passes through RUN with remaining == 0, which
  // makes RUN's remaining == 0 branch the single end-of-segment decision.
  always_comb begin
    state_n      = state;
    div_en       = 1'b0;
    done_n       = 1'b0;
    underrun_set = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (start && seg.seg_valid) state_n = ST_LOAD;
      end
      ST_LOAD, ST_RUN: begin
        div_en = (remaining != '0) || abort_req;
        if (abort_req) begin
          state_n = ST_ABORT;
        end else if (state == ST_LOAD) begin
          state_n = ST_RUN;
        end else if (remaining == '0) begin
          if (last) begin
            state_n = ST_IDLE;
            done_n  = 1'b1;
          end else if (seg.seg_valid) begin
            state_n = ST_LOAD;
          end else begin
            state_n      = ST_ABORT;
            underrun_set = 1'b1;
          end
        end
      end
      ST_ABORT: begin
        if (gen_stopped && !acc_step) state_n = ST_IDLE;
        else                          div_en  = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign div_clr   = (state_n == ST_LOAD);
  assign start_clr = (state == ST_IDLE) && start;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Segment fields are captured on the edge entering LOAD; the source keeps
  // the head stable until the handshake completes at the end of LOAD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      remaining     <= '0;
      last          <= 1'b0;
      load          <= 1'b0;
      seg.seg_ready <= 1'b0;
      set_v         <= 1'b0;
      set_a         <= 1'b0;
      set_j         <= 1'b0;
      v_val         <= '0;
      a_val         <= '0;
      j_val         <= '0;
      abort         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      load          <= (state_n == ST_LOAD);
      seg.seg_ready <= (state_n == ST_LOAD);
      set_v         <= (state_n == ST_LOAD) && seg.seg_set[SEG_SET_V];
      set_a         <= (state_n == ST_LOAD) && seg.seg_set[SEG_SET_A];
      set_j         <= (state_n == ST_LOAD) && seg.seg_set[SEG_SET_J];
      abort         <= (state_n == ST_ABORT);
      busy          <= (state_n != ST_IDLE);
      done          <= done_n;

      if (state_n == ST_LOAD) begin
        v_val     <= seg.seg_v;
        a_val     <= seg.seg_a;
        j_val     <= seg.seg_j;
        remaining <= seg.seg_len;
        last      <= seg.seg_last;
      end else if (div_wrap && (remaining != '0) && (state != ST_ABORT)) begin
        remaining <= remaining - LEN_W'(1);
      end

      if (start_clr)         underrun <= 1'b0;
      else if (underrun_set) underrun <= 1'b1;
    end
  end

`ifdef MOTION_SEQ_STEPCOUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_count <= '0;
    end else if (start_clr) begin
      step_count <= '0;
    end else if (div_wrap && (step_count != '1)) begin
      step_count <= step_count + 32'd1;
    end
  end
`endif

endmodule

// File: doc/motion_segment_sequencer.md
Name: motion_segment_sequencer

Overview:
Sequences one acc_profile_gen channel through a queue of motion segments (jerk/acceleration/velocity load plus duration).
- Pops segment commands from an upstream valid/ready queue.
- Issues the generator's load/set_* pulses.
- Produces acc_step at a programmable tick period and counts segment length.
- Drives the generator's abort input until the channel reports stopped.

Parameters:
LEN_W, 32, width of segment length (acc_step ticks per segment)
DIV_W, 16, width of acc_step tick period divider

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
start  in  1  one-cycle pulse; begins execution from IDLE
abort_req  in  1  level; request controlled stop
step_div  in  DIV_W  acc_step period in clk cycles; 0 treated as 1
seg_valid  in  1  segment available
seg_ready  out  1  segment accepted this cycle
seg_v  in  32  velocity value (signed)
seg_a  in  32  acceleration value (signed)
seg_j  in  32  jerk value (signed)
seg_set  in  3  {set_j,set_a,set_v} enables
seg_last  in  1  final segment of move
seg_len  in  LEN_W  acc_step ticks to run this segment
gen_stopped  in  1  generator stopped output
acc_step  out  1  generator acc_step pulse
load  out  1  generator load pulse
set_v, set_a, set_j  out  1 each  generator set enables, valid with load
v_val, a_val, j_val  out  32 each  generator load values, registered
abort  out  1  generator abort
busy  out  1  state != IDLE
done  out  1  one-cycle pulse; last segment completed
underrun  out  1  sticky; queue empty mid-move; cleared by start

Behaviour:
- Reset: all outputs 0; state IDLE; counters 0.
- All outputs are registered.
- States: IDLE, LOAD, RUN, ABORT.
- IDLE:
  - start with seg_valid=1 -> LOAD. Clears underrun.
  - start with seg_valid=0 -> stays IDLE; no done pulse.
- LOAD (exactly one cycle):
  - Asserts load, the set_* enables from seg_set, and the *_val outputs from seg_*.
  - Asserts seg_ready=1 (handshake completes).
  - Latches seg_len into remaining, seg_last into last.
  - Resets the divider.
  - remaining=0 -> end-of-segment decision next cycle; no acc_step issued.
  - Otherwise -> RUN.
- RUN:
  - Divider counts clk cycles. acc_step is asserted for one cycle every max(step_div,1) cycles.
  - The first acc_step falls max(step_div,1) cycles after the load cycle.
  - step_div is sampled at each divider reload.
  - remaining decrements on each acc_step. The cycle after the acc_step that takes remaining to 0 is the end-of-segment decision.
- End-of-segment decision:
  - last=1 -> done pulse, IDLE.
  - Else seg_valid=1 -> LOAD; the next load lands one cycle after the final acc_step, with no gap tick.
  - Else -> set underrun, enter ABORT.
- ABORT:
  - abort=1 held; acc_step continues at the divider rate; load never asserted.
  - On gen_stopped=1 sampled in a cycle with no acc_step -> IDLE. done is not pulsed.
- Priority and simultaneous events:
  - abort_req in LOAD or RUN -> ABORT next cycle, overriding the end-of-segment decision.
  - A load issued in the same cycle still completes.
  - abort_req in IDLE is ignored.
  - start outside IDLE is ignored.
- seg_ready is asserted only in LOAD; it never depends combinationally on seg_valid.
- Asynchronous reset mid-segment returns to IDLE with all outputs low. The generator is reset separately.
- Arithmetic: remaining and divider are unsigned and never wrap. Decrement happens only when non-zero.

Optional Feature:
MOTION_SEQ_STEPCOUNT_EN:
- Defined: adds output step_count[31:0], counting acc_step pulses since the last start. It is cleared on start or reset and saturates at 0xFFFFFFFF.
- Not defined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package motion_pkg holds:
  - the state enum encoding (IDLE=0, LOAD=1, RUN=2, ABORT=3);
  - SEG_SET_V/A/J bit index constants;
  - default LEN_W/DIV_W.
- One natural sub-module: motion_tick_div, the acc_step divider with reload, enable and tick output. It is reused by the other channel sequencers.

Test Plan:
- Single segment, step_div=4, seg_len=3, seg_last=1, seg_set=3'b111: load at cycle L; acc_step at L+4, L+8, L+12; done at L+13; busy falls at L+13.
- Two queued segments, lengths 2 and 1, step_div=1: second load exactly one cycle after the 2nd acc_step; exactly 3 acc_steps total; single done pulse.
- Queue empty after a non-last segment: underrun=1, abort=1. acc_step continues; after gen_stopped=1 the block returns to IDLE with no done pulse. underrun clears on the next start.
- abort_req asserted mid-RUN with remaining=5: abort asserted next cycle; no further load; seg_ready stays 0 while seg_valid=1.
- seg_len=0 segment followed by seg_len=1 (last): two consecutive loads with one decision cycle between; exactly one acc_step.
- Reset asserted asynchronously during RUN: all outputs 0 immediately, without waiting for a clock edge. A subsequent start behaves as from power-up. With MOTION_SEQ_STEPCOUNT_EN, step_count reads 0.
